// File: rtl/pnode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pnode_pkg
// Description : Shared widths, pnode field offsets, types and helpers for the
//               pnode tagger.
// Revision    : 1.0 - initial release
// ============================================================================
package pnode_pkg;

   localparam int PNODE_WIDTH = 74;
   localparam int MATCH_WIDTH = 10;
   localparam int TAG_WIDTH   = 8;

   localparam int TAG_MSB = 73;
   localparam int SOP_BIT = 65;
   localparam int EOP_BIT = 64;

   localparam logic [1:0] STAT_ADDR_PKT         = 2'd0;
   localparam logic [1:0] STAT_ADDR_MATCH       = 2'd1;
   localparam logic [1:0] STAT_ADDR_DROP_ERR    = 2'd2;
   localparam logic [1:0] STAT_ADDR_OUTSTANDING = 2'd3;

   typedef struct packed {
      logic [TAG_WIDTH-1:0] tag;
      logic                 sop;
      logic                 eop;
      logic [63:0]          data;
   } pnode_word_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PKT  = 1'b1
   } tagger_state_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pnode_tagger_if.sv
`default_nettype none
// ============================================================================
// Module      : pnode_tagger_if
// Description : Rx stream, pnode stream, match result and stats bus bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface pnode_tagger_if;
   import pnode_pkg::*;

   logic [63:0]            avalon_st_rx_data;
   logic                   avalon_st_rx_sop;
   logic                   avalon_st_rx_eop;
   logic                   avalon_st_rx_valid;
   logic                   avalon_st_rx_ready;
   logic [PNODE_WIDTH-1:0] pnode_data;
   logic                   pnode_valid;
   logic                   pnode_ready;
   logic [MATCH_WIDTH-1:0] match_data_out;
   logic                   match_data_valid;
   logic                   match_data_ack;
   logic [7:0]             result_tag;
   logic                   result_valid;
   logic                   result_err;
   logic [1:0]             avs_stat_address;
   logic                   avs_stat_read;
   logic [31:0]            avs_stat_readdata;

   modport slave (
      input  avalon_st_rx_data, avalon_st_rx_sop, avalon_st_rx_eop, avalon_st_rx_valid,
      output avalon_st_rx_ready,
      output pnode_data, pnode_valid,
      input  pnode_ready,
      input  match_data_out, match_data_valid,
      output match_data_ack, result_tag, result_valid, result_err,
      input  avs_stat_address, avs_stat_read,
      output avs_stat_readdata
   );

   modport master (
      output avalon_st_rx_data, avalon_st_rx_sop, avalon_st_rx_eop, avalon_st_rx_valid,
      input  avalon_st_rx_ready,
      input  pnode_data, pnode_valid,
      output pnode_ready,
      output match_data_out, match_data_valid,
      input  match_data_ack, result_tag, result_valid, result_err,
      output avs_stat_address, avs_stat_read,
      input  avs_stat_readdata
   );

endinterface
`default_nettype wire

// File: rtl/pnode_skid.sv
`default_nettype none
// ============================================================================
// Module      : pnode_skid
// Description : Two-entry valid/ready skid buffer with registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module pnode_skid import pnode_pkg::*; #(
   parameter int WIDTH = PNODE_WIDTH
) (
   input  wire logic             clock,
   input  wire logic             reset,
   input  wire logic [WIDTH-1:0] in_data,
   input  wire logic             in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  wire logic             out_ready
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign out_data  = r_mem[r_rd_ptr];
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/pnode_tagger.sv
`default_nettype none
// ============================================================================
// Module      : pnode_tagger
// Description : Tags rx packets into pnode words, retires match results under
//               a credit limit, exposes stats. Optional result order check
//               enabled by defining PNODE_TAG_ORDER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pnode_tagger import pnode_pkg::*; #(
   parameter int TAG_WIDTH       = 8,
   parameter int MAX_OUTSTANDING = 16,
   parameter int TAG_INIT        = 0
) (
   input  wire logic     clock,
   input  wire logic     reset,
   pnode_tagger_if.slave bus
);

   localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

   tagger_state_t          r_state;
   logic [TAG_WIDTH-1:0]   r_tag;
   logic [7:0]             r_outstanding;
   logic [31:0]            r_pkt_cnt;
   logic [31:0]            r_match_cnt;
   logic [15:0]            r_drop_cnt;
   logic [15:0]            r_err_cnt;
   logic [31:0]            r_readdata;
   logic [TAG_WIDTH-1:0]   r_result_tag;
   logic                   r_result_valid;
   logic                   r_result_err;

   logic                   w_in_pkt;
   logic                   w_skid_in_ready;
   logic                   w_accept;
   logic                   w_fwd;
   logic                   w_issue;
   logic                   w_drop;
   logic                   w_pop;
   logic                   w_spurious;
   logic                   w_retire;
   logic                   w_integ_err;
   logic                   w_order_err;
   logic [TAG_WIDTH-1:0]   w_match_tag;
   logic [PNODE_WIDTH-1:0] w_word;

   assign w_in_pkt = (r_state == PKT);

   // Credit backpressure only gates packet starts; an open packet always drains.
   assign bus.avalon_st_rx_ready = !reset && w_skid_in_ready &&
                                   !(!w_in_pkt && (r_outstanding == MAX_OUT));

   assign w_accept = bus.avalon_st_rx_valid && bus.avalon_st_rx_ready;
   assign w_fwd    = w_accept && (w_in_pkt || bus.avalon_st_rx_sop);
   assign w_issue  = w_fwd && bus.avalon_st_rx_eop;
   // Stray sop inside a packet and orphan words outside one both count as drops.
   assign w_drop   = w_accept && (w_in_pkt == bus.avalon_st_rx_sop);

   always_comb begin
      w_word                         = '0;
      w_word[TAG_MSB -: TAG_WIDTH]   = r_tag;
      w_word[SOP_BIT]                = bus.avalon_st_rx_sop && !w_in_pkt;
      w_word[EOP_BIT]                = bus.avalon_st_rx_eop;
      w_word[EOP_BIT-1:0]            = bus.avalon_st_rx_data;
   end

   pnode_skid #(
      .WIDTH (PNODE_WIDTH)
   ) u_skid (
      .clock     (clock),
      .reset     (reset),
      .in_data   (w_word),
      .in_valid  (w_fwd),
      .in_ready  (w_skid_in_ready),
      .out_data  (bus.pnode_data),
      .out_valid (bus.pnode_valid),
      .out_ready (bus.pnode_ready)
   );

   assign w_pop              = bus.match_data_valid && !reset;
   assign bus.match_data_ack = w_pop;
   assign w_match_tag        = bus.match_data_out[TAG_WIDTH-1:0];
   assign w_integ_err        = (bus.match_data_out[9:8] != bus.match_data_out[7:6]);
   assign w_spurious         = w_pop && (r_outstanding == 8'd0);
   assign w_retire           = w_pop && !w_spurious;

`ifdef PNODE_TAG_ORDER_CHECK_EN
   logic [TAG_WIDTH-1:0] r_expect_tag;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_expect_tag <= TAG_WIDTH'(TAG_INIT);
      end else if (w_retire) begin
         r_expect_tag <= r_expect_tag + TAG_WIDTH'(1);
      end
   end

   assign w_order_err = w_retire && (w_match_tag != r_expect_tag);
`else
   assign w_order_err = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= IDLE;
         r_tag          <= TAG_WIDTH'(TAG_INIT);
         r_outstanding  <= 8'd0;
         r_pkt_cnt      <= 32'd0;
         r_match_cnt    <= 32'd0;
         r_drop_cnt     <= 16'd0;
         r_err_cnt      <= 16'd0;
         r_readdata     <= 32'd0;
         r_result_tag   <= '0;
         r_result_valid <= 1'b0;
         r_result_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            case (r_state)
               IDLE:    if (bus.avalon_st_rx_sop && !bus.avalon_st_rx_eop) r_state <= PKT;
               PKT:     if (bus.avalon_st_rx_eop) r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end

         if (w_issue) begin
            r_tag     <= r_tag + TAG_WIDTH'(1);
            r_pkt_cnt <= sat_inc32(r_pkt_cnt);
         end

         case ({w_issue, w_retire})
            2'b10:   r_outstanding <= r_outstanding + 8'd1;
            2'b01:   r_outstanding <= r_outstanding - 8'd1;
            default: r_outstanding <= r_outstanding;
         endcase

         if (w_drop)                     r_drop_cnt  <= sat_inc16(r_drop_cnt);
         if (w_spurious || w_order_err)  r_err_cnt   <= sat_inc16(r_err_cnt);
         if (w_retire)                   r_match_cnt <= sat_inc32(r_match_cnt);

         r_result_valid <= w_pop;
         r_result_err   <= w_pop && (w_integ_err || w_spurious || w_order_err);
         if (w_pop) r_result_tag <= w_match_tag;

         if (bus.avs_stat_read) begin
            case (bus.avs_stat_address)
               STAT_ADDR_PKT:      r_readdata <= r_pkt_cnt;
               STAT_ADDR_MATCH:    r_readdata <= r_match_cnt;
               STAT_ADDR_DROP_ERR: r_readdata <= {r_drop_cnt, r_err_cnt};
               default:            r_readdata <= {24'd0, r_outstanding};
            endcase
         end
      end
   end

   assign bus.result_tag        = r_result_tag;
   assign bus.result_valid      = r_result_valid;
   assign bus.result_err        = r_result_err;
   assign bus.avs_stat_readdata = r_readdata;

endmodule
`default_nettype wire
